// File: rtl/ghost_move_controller.sv
// Ghost movement FSM: steps one ghost per frame tick and chases a target at tile-aligned positions.
// Optional macro GHOST_RANDOM_TIEBREAK_EN rotates the fallback direction scan using a 16-bit LFSR.
module ghost_move_controller #(
   parameter int          TILE_SHIFT = 4,
   parameter int          STEP       = 1,
   parameter logic [10:0] START_X    = 11'd320,
   parameter logic [9:0]  START_Y    = 10'd240,
   parameter logic [10:0] X_MAX      = 11'd639,
   parameter logic [9:0]  Y_MAX      = 10'd479,
   parameter int          SETTLE     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [10:0] target_x,
   input  logic [9:0]  target_y,
   input  logic [3:0]  valid_moves,
   output logic [10:0] pos_x,
   output logic [9:0]  pos_y,
   output logic [3:0]  dir,
   output logic        busy,
   output logic        stuck
);

   localparam logic [3:0]  DIR_RIGHT = 4'b0001;
   localparam logic [3:0]  DIR_UP    = 4'b0010;
   localparam logic [3:0]  DIR_DOWN  = 4'b0100;
   localparam logic [3:0]  DIR_LEFT  = 4'b1000;
   localparam int          CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [11:0] STEP_X    = 12'(STEP);
   localparam logic [10:0] STEP_Y    = 11'(STEP);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DECIDE, S_STEP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   wait_cnt, wait_cnt_n;
   logic [10:0]     pos_x_n;
   logic [9:0]      pos_y_n;
   logic [3:0]      dir_n;
   logic            stuck_n;
   logic            aligned;
   logic [1:0]      scan_start;

   logic [3:0]        cand_nr, cand, pref_x, pref_y, prim, sec, choice;
   logic signed [11:0] dx;
   logic signed [10:0] dy;
   logic [11:0]       adx;
   logic [10:0]       ady;
   logic              found;

   // Fallback scan list: UP, LEFT, DOWN, RIGHT.
   function automatic logic [3:0] fallback_dir(input logic [1:0] k);
      case (k)
         2'd0:    fallback_dir = DIR_UP;
         2'd1:    fallback_dir = DIR_LEFT;
         2'd2:    fallback_dir = DIR_DOWN;
         default: fallback_dir = DIR_RIGHT;
      endcase
   endfunction

`ifdef GHOST_RANDOM_TIEBREAK_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign scan_start = lfsr[1:0];
`else
   assign scan_start = 2'd0;
`endif

   assign aligned = (pos_x[TILE_SHIFT-1:0] == '0) && (pos_y[TILE_SHIFT-1:0] == '0);
   assign busy    = (state != S_IDLE);

   // Direction choice; reversing dir is a plain bit reversal of the one-hot code.
   always_comb begin
      cand_nr = valid_moves & ~{dir[0], dir[1], dir[2], dir[3]};
      cand    = (cand_nr == 4'b0) ? valid_moves : cand_nr;
      dx      = $signed({1'b0, target_x}) - $signed({1'b0, pos_x});
      dy      = $signed({1'b0, target_y}) - $signed({1'b0, pos_y});
      adx     = dx[11] ? 12'(-dx) : 12'(dx);
      ady     = dy[10] ? 11'(-dy) : 11'(dy);
      pref_x  = (dx == 12'sd0) ? 4'b0 : (dx[11] ? DIR_LEFT : DIR_RIGHT);
      pref_y  = (dy == 11'sd0) ? 4'b0 : (dy[10] ? DIR_UP : DIR_DOWN);
      prim    = (adx >= {1'b0, ady}) ? pref_x : pref_y;
      sec     = (adx >= {1'b0, ady}) ? pref_y : pref_x;
      choice  = dir;
      found   = 1'b0;
      if ((prim & cand) != 4'b0) begin
         choice = prim;
      end else if ((sec & cand) != 4'b0) begin
         choice = sec;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!found && ((cand & fallback_dir(scan_start + 2'(i))) != 4'b0)) begin
               choice = fallback_dir(scan_start + 2'(i));
               found  = 1'b1;
            end
         end
      end
   end

   // Next-state and datapath updates; ticks outside IDLE are simply ignored.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      pos_x_n    = pos_x;
      pos_y_n    = pos_y;
      dir_n      = dir;
      stuck_n    = stuck;
      case (state)
         S_IDLE: begin
            if (tick) begin
               if (aligned) begin
                  state_n    = S_WAIT;
                  wait_cnt_n = '0;
               end else begin
                  state_n = S_STEP;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == CW'(SETTLE - 1))
               state_n = S_DECIDE;
            else
               wait_cnt_n = wait_cnt + 1'b1;
         end
         S_DECIDE: begin
            if (cand == 4'b0) begin
               stuck_n = 1'b1;
               state_n = S_IDLE;
            end else begin
               stuck_n = 1'b0;
               dir_n   = choice;
               state_n = S_STEP;
            end
         end
         S_STEP: begin
            case (dir)
               DIR_RIGHT: pos_x_n = (({1'b0, pos_x} + STEP_X) > {1'b0, X_MAX}) ? X_MAX : 11'({1'b0, pos_x} + STEP_X);
               DIR_LEFT:  pos_x_n = ({1'b0, pos_x} < STEP_X) ? 11'd0 : 11'({1'b0, pos_x} - STEP_X);
               DIR_DOWN:  pos_y_n = (({1'b0, pos_y} + STEP_Y) > {1'b0, Y_MAX}) ? Y_MAX : 10'({1'b0, pos_y} + STEP_Y);
               DIR_UP:    pos_y_n = ({1'b0, pos_y} < STEP_Y) ? 10'd0 : 10'({1'b0, pos_y} - STEP_Y);
               default:   pos_x_n = pos_x;
            endcase
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         pos_x    <= START_X;
         pos_y    <= START_Y;
         dir      <= DIR_LEFT;
         stuck    <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         pos_x    <= pos_x_n;
         pos_y    <= pos_y_n;
         dir      <= dir_n;
         stuck    <= stuck_n;
      end
   end

endmodule

// File: doc/ghost_move_controller.md
Name: ghost_move_controller

Overview:
- Downstream consumer of the valid-move detector. Owns one ghost's position register.
- Presents that position to the detector and, on each frame tick, steps the ghost.
- At tile-aligned positions it samples the one-hot valid_moves and chooses a direction that chases a target (Pacman's position).
- Its pos_x and pos_y outputs feed the detector and the renderer.

Parameters:
- TILE_SHIFT, 4: tile size is 2^TILE_SHIFT pixels; a position is aligned when pos_x[TILE_SHIFT-1:0]==0 and pos_y[TILE_SHIFT-1:0]==0.
- STEP, 1: pixels moved per accepted tick.
- START_X, 11'd320: reset x.
- START_Y, 10'd240: reset y.
- X_MAX, 11'd639: right clamp; left clamp is 0.
- Y_MAX, 10'd479: bottom clamp; top clamp is 0.
- SETTLE, 2: cycles (at least 1) waited after alignment so the detector output reflects the current position.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- tick  input  1  one-cycle frame-step pulse
- target_x  input  11  chase target x
- target_y  input  10  chase target y
- valid_moves  input  4  from detector, one-hot bits: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000
- pos_x  output  11  ghost x, registered
- pos_y  output  10  ghost y, registered
- dir  output  4  current direction, one-hot, same encoding
- busy  output  1  high whenever state != IDLE
- stuck  output  1  high when the last decision found no valid move

Behaviour:
- Reset values: pos=(START_X,START_Y), dir=LEFT (4'b1000), busy=0, stuck=0, state=IDLE, wait counter=0.
- Reset mid-operation takes effect at the next edge and aborts any WAIT/DECIDE/STEP in progress.
- States: IDLE, WAIT, DECIDE, STEP.
- IDLE:
  - On tick at edge E0: go to WAIT if aligned, else go to STEP.
  - Without tick: stay in IDLE.
- Ticks arriving while busy are dropped, not queued.
- WAIT: count SETTLE cycles, then go to DECIDE. valid_moves is sampled in DECIDE only.
- DECIDE (one cycle):
  - cand = valid_moves & ~rev(dir); rev swaps RIGHT<->LEFT and UP<->DOWN.
  - If cand==0, set cand=valid_moves (reversal allowed at a dead end).
  - If cand is still 0: stuck<=1, dir unchanged, go to IDLE with no move.
  - Otherwise stuck<=0 and pick, in this order:
    1. Primary axis toward target. Primary is x if |dx|>=|dy|, else y, with dx=target_x-pos_x and dy=target_y-pos_y computed signed at 12 and 11 bits.
    2. Secondary axis toward target.
    3. Fixed priority UP, LEFT, DOWN, RIGHT.
  - An axis with delta 0 has no preferred direction and is skipped.
  - Latch the chosen direction into dir, then go to STEP.
- STEP (one cycle):
  - pos moves by STEP in direction dir; return to IDLE.
  - Results are clamped to [0,X_MAX] and [0,Y_MAX]; clamping does not set stuck.
- STEP from a non-aligned position continues in the current dir; valid_moves is ignored.
- Latency, tick sampled at E0:
  - Non-aligned: pos updates at E1.
  - Aligned: pos updates at E(SETTLE+2); dir updates at E(SETTLE+1).
- dir is only ever 0001, 0010, 0100 or 1000; it is never zero and never multi-hot.
- Simultaneous rst and tick: rst wins.

Optional Feature:
- Macro: GHOST_RANDOM_TIEBREAK_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - At the fallback step (step 3 of the selection order), the priority scan starts at index lfsr[1:0] of the list UP, LEFT, DOWN, RIGHT and rotates.
- Undefined: no LFSR; the fallback is the fixed order UP, LEFT, DOWN, RIGHT.
- Steps 1 and 2 of the selection order are identical either way.

Test Plan:
- Reset -> pos=(320,240), dir=1000, busy=0, stuck=0. Assert rst during WAIT -> next edge back to reset values.
- After reset: target=(100,240), valid_moves=1111, tick -> dir=1000 at E3, pos_x=319 at E4 (SETTLE=2).
- After reset: target=(400,240), valid_moves=1111, tick -> RIGHT is excluded as a reversal, dy=0 -> dir=0010, pos=(320,239) at E4.
- After reset: valid_moves=0001, target=(100,240), tick -> dead end, reversal allowed -> dir=0001, pos_x=321, stuck=0.
- After reset: valid_moves=0000, tick -> stuck=1 at E3, pos stays (320,240), dir stays 1000.
- At pos_x=319 (non-aligned) with valid_moves=0000, tick -> pos_x=318 at E1. A second tick during busy is dropped, leaving exactly one step.
